ex_mem: RTL and testbench

- EX/MEM pipeline register of the 5-stage RV32 pipeline; sits directly downstream of the ID/EX register and the ALU.
- Captures ALU result, store data, link/immediate values and MEM/WB control on each clk edge.
- Adds stall (hold), flush (bubble insert), a per-stage valid bit, and a precomputed forwarding path from MEM back to EX.
- Keeps a bubble counter for pipeline-efficiency debug.

---
 rtl/ex_mem_if.sv | 69 ++++++
 rtl/ex_mem.sv | 138 +++++++++++++
 tb/tb_ex_mem.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// rtl/ex_mem_if.sv - EX/MEM pipeline register bus: EX-side inputs, MEM-side and forwarding outputs.
// Optional trace fields exist only when EX_MEM_TRACE_EN is defined.
interface ex_mem_if #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [DW-1:0]    ex_alu_c;
  logic [DW-1:0]    ex_rD2;
  logic [DW-1:0]    ex_pc4;
  logic [DW-1:0]    ex_imm;
  logic [RW-1:0]    ex_wR;
  logic             ex_ram_we;
  logic             ex_rf_we;
  logic [1:0]       ex_rf_wsel;
  logic             stall;
  logic             flush;

  logic             mem_valid;
  logic [DW-1:0]    mem_alu_c;
  logic [DW-1:0]    mem_rD2;
  logic [DW-1:0]    mem_pc4;
  logic [DW-1:0]    mem_imm;
  logic [RW-1:0]    mem_wR;
  logic             mem_ram_we;
  logic             mem_rf_we;
  logic [1:0]       mem_rf_wsel;
  logic             fwd_we;
  logic [RW-1:0]    fwd_wR;
  logic [DW-1:0]    fwd_data;
  logic             fwd_is_load;
  logic [CNT_W-1:0] bubble_cnt;

`ifdef EX_MEM_TRACE_EN
  logic [DW-1:0]    ex_pc;
  logic [31:0]      ex_inst;
  logic [DW-1:0]    mem_pc;
  logic [31:0]      mem_inst;

  modport master (
    output ex_valid, ex_alu_c, ex_rD2, ex_pc4, ex_imm, ex_wR, ex_ram_we, ex_rf_we,
           ex_rf_wsel, stall, flush, ex_pc, ex_inst,
    input  mem_valid, mem_alu_c, mem_rD2, mem_pc4, mem_imm, mem_wR, mem_ram_we,
           mem_rf_we, mem_rf_wsel, fwd_we, fwd_wR, fwd_data, fwd_is_load, bubble_cnt,
           mem_pc, mem_inst
  );
  modport slave (
    input  ex_valid, ex_alu_c, ex_rD2, ex_pc4, ex_imm, ex_wR, ex_ram_we, ex_rf_we,
           ex_rf_wsel, stall, flush, ex_pc, ex_inst,
    output mem_valid, mem_alu_c, mem_rD2, mem_pc4, mem_imm, mem_wR, mem_ram_we,
           mem_rf_we, mem_rf_wsel, fwd_we, fwd_wR, fwd_data, fwd_is_load, bubble_cnt,
           mem_pc, mem_inst
  );
`else
  modport master (
    output ex_valid, ex_alu_c, ex_rD2, ex_pc4, ex_imm, ex_wR, ex_ram_we, ex_rf_we,
           ex_rf_wsel, stall, flush,
    input  mem_valid, mem_alu_c, mem_rD2, mem_pc4, mem_imm, mem_wR, mem_ram_we,
           mem_rf_we, mem_rf_wsel, fwd_we, fwd_wR, fwd_data, fwd_is_load, bubble_cnt
  );
  modport slave (
    input  ex_valid, ex_alu_c, ex_rD2, ex_pc4, ex_imm, ex_wR, ex_ram_we, ex_rf_we,
           ex_rf_wsel, stall, flush,
    output mem_valid, mem_alu_c, mem_rD2, mem_pc4, mem_imm, mem_wR, mem_ram_we,
           mem_rf_we, mem_rf_wsel, fwd_we, fwd_wR, fwd_data, fwd_is_load, bubble_cnt
  );
`endif
endinterface

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall, flush, MEM->EX forwarding and bubble counter.
// Define EX_MEM_TRACE_EN to also carry pc/inst for commit tracing.
module ex_mem #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);
  logic             valid_q, valid_d;
  logic [DW-1:0]    alu_c_q, alu_c_d;
  logic [DW-1:0]    rd2_q, rd2_d;
  logic [DW-1:0]    pc4_q, pc4_d;
  logic [DW-1:0]    imm_q, imm_d;
  logic [RW-1:0]    wr_q, wr_d;
  logic             ram_we_q, ram_we_d;
  logic             rf_we_q, rf_we_d;
  logic [1:0]       wsel_q, wsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef EX_MEM_TRACE_EN
  logic [DW-1:0]    pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
`endif

  always_comb begin
    valid_d  = valid_q;
    alu_c_d  = alu_c_q;
    rd2_d    = rd2_q;
    pc4_d    = pc4_q;
    imm_d    = imm_q;
    wr_d     = wr_q;
    ram_we_d = ram_we_q;
    rf_we_d  = rf_we_q;
    wsel_d   = wsel_q;
    cnt_d    = cnt_q;
`ifdef EX_MEM_TRACE_EN
    pc_d     = pc_q;
    inst_d   = inst_q;
`endif
    if (bus.flush) begin
      valid_d  = 1'b0;
      alu_c_d  = '0;
      rd2_d    = '0;
      pc4_d    = '0;
      imm_d    = '0;
      wr_d     = '0;
      ram_we_d = 1'b0;
      rf_we_d  = 1'b0;
      wsel_d   = 2'd0;
`ifdef EX_MEM_TRACE_EN
      pc_d     = '0;
      inst_d   = 32'h0000_0013;
`endif
    end else if (!bus.stall) begin
      valid_d  = bus.ex_valid;
      alu_c_d  = bus.ex_alu_c;
      rd2_d    = bus.ex_rD2;
      pc4_d    = bus.ex_pc4;
      imm_d    = bus.ex_imm;
      wr_d     = bus.ex_wR;
      ram_we_d = bus.ex_ram_we & bus.ex_valid;
      rf_we_d  = bus.ex_rf_we & bus.ex_valid;
      wsel_d   = bus.ex_rf_wsel;
`ifdef EX_MEM_TRACE_EN
      pc_d     = bus.ex_pc;
      inst_d   = bus.ex_inst;
`endif
    end
    // A flush counts as a bubble even when a stall is also requested.
    if ((bus.flush || !bus.stall) && !valid_d && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_c_q  <= '0;
      rd2_q    <= '0;
      pc4_q    <= '0;
      imm_q    <= '0;
      wr_q     <= '0;
      ram_we_q <= 1'b0;
      rf_we_q  <= 1'b0;
      wsel_q   <= 2'd0;
      cnt_q    <= '0;
`ifdef EX_MEM_TRACE_EN
      pc_q     <= '0;
      inst_q   <= '0;
`endif
    end else begin
      valid_q  <= valid_d;
      alu_c_q  <= alu_c_d;
      rd2_q    <= rd2_d;
      pc4_q    <= pc4_d;
      imm_q    <= imm_d;
      wr_q     <= wr_d;
      ram_we_q <= ram_we_d;
      rf_we_q  <= rf_we_d;
      wsel_q   <= wsel_d;
      cnt_q    <= cnt_d;
`ifdef EX_MEM_TRACE_EN
      pc_q     <= pc_d;
      inst_q   <= inst_d;
`endif
    end
  end

  assign bus.mem_valid   = valid_q;
  assign bus.mem_alu_c   = alu_c_q;
  assign bus.mem_rD2     = rd2_q;
  assign bus.mem_pc4     = pc4_q;
  assign bus.mem_imm     = imm_q;
  assign bus.mem_wR      = wr_q;
  assign bus.mem_ram_we  = ram_we_q;
  assign bus.mem_rf_we   = rf_we_q;
  assign bus.mem_rf_wsel = wsel_q;
  assign bus.bubble_cnt  = cnt_q;
`ifdef EX_MEM_TRACE_EN
  assign bus.mem_pc      = pc_q;
  assign bus.mem_inst    = inst_q;
`endif

  // Loads are not forwardable from MEM; the hazard unit stalls on fwd_is_load instead.
  assign bus.fwd_we      = valid_q & rf_we_q & (wr_q != '0) & (wsel_q != 2'd1);
  assign bus.fwd_is_load = valid_q & rf_we_q & (wsel_q == 2'd1) & (wr_q != '0);
  assign bus.fwd_wR      = wr_q;

  always_comb begin
    case (wsel_q)
      2'd0:    bus.fwd_data = alu_c_q;
      2'd2:    bus.fwd_data = pc4_q;
      2'd3:    bus.fwd_data = imm_q;
      default: bus.fwd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - self-checking bench for ex_mem: vector table, corner sequences, random vs. model.
module tb_ex_mem;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_if #(.DW(DW), .RW(RW), .CNT_W(CW)) bus ();
  ex_mem #(.DW(DW), .RW(RW), .CNT_W(CW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        valid, ram_we, rf_we, stall, flush;
    logic [31:0] alu, rd2, pc4, imm;
    logic [4:0]  wr;
    logic [1:0]  wsel;
    logic        e_valid, e_ram, e_rf, e_fwe, e_load;
    logic [4:0]  e_fwr;
    logic [31:0] e_fdata;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[8];

  // Reference model: what the MEM stage should be holding.
  logic        m_valid, m_ram, m_rf;
  logic [31:0] m_alu, m_rd2, m_pc4, m_imm;
  logic [4:0]  m_wr;
  logic [1:0]  m_wsel;
  int          m_bubbles;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] wr,
                       input logic ram, input logic rf, input logic [1:0] ws,
                       input logic st, input logic fl);
    bus.ex_valid = v; bus.ex_alu_c = alu; bus.ex_rD2 = rd2; bus.ex_pc4 = pc4;
    bus.ex_imm = imm; bus.ex_wR = wr; bus.ex_ram_we = ram; bus.ex_rf_we = rf;
    bus.ex_rf_wsel = ws; bus.stall = st; bus.flush = fl;
  endtask

  task automatic model_reset();
    m_valid = 0; m_ram = 0; m_rf = 0; m_alu = 0; m_rd2 = 0; m_pc4 = 0; m_imm = 0;
    m_wr = 0; m_wsel = 0; m_bubbles = 0;
  endtask

  task automatic model_step();
    if (bus.flush) begin
      model_reset_fields();
      m_bubbles++;
    end else if (!bus.stall) begin
      m_valid = bus.ex_valid;
      m_alu = bus.ex_alu_c; m_rd2 = bus.ex_rD2; m_pc4 = bus.ex_pc4; m_imm = bus.ex_imm;
      m_wr = bus.ex_wR; m_wsel = bus.ex_rf_wsel;
      m_ram = bus.ex_ram_we && bus.ex_valid;
      m_rf  = bus.ex_rf_we && bus.ex_valid;
      if (!bus.ex_valid) m_bubbles++;
    end
  endtask

  task automatic model_reset_fields();
    m_valid = 0; m_ram = 0; m_rf = 0; m_alu = 0; m_rd2 = 0; m_pc4 = 0; m_imm = 0;
    m_wr = 0; m_wsel = 0;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] efd;
    int          ecnt;
    efd  = (m_wsel == 2'd0) ? m_alu : (m_wsel == 2'd2) ? m_pc4 : (m_wsel == 2'd3) ? m_imm : 32'd0;
    ecnt = (m_bubbles > 15) ? 15 : m_bubbles;
    chk({tag, ".valid"}, bus.mem_valid, m_valid);
    chk({tag, ".alu"}, bus.mem_alu_c, m_alu);
    chk({tag, ".rd2"}, bus.mem_rD2, m_rd2);
    chk({tag, ".pc4"}, bus.mem_pc4, m_pc4);
    chk({tag, ".imm"}, bus.mem_imm, m_imm);
    chk({tag, ".wr"}, bus.mem_wR, m_wr);
    chk({tag, ".wsel"}, bus.mem_rf_wsel, m_wsel);
    chk({tag, ".ram_we"}, bus.mem_ram_we, m_ram);
    chk({tag, ".rf_we"}, bus.mem_rf_we, m_rf);
    chk({tag, ".fwd_we"}, bus.fwd_we, m_valid && m_rf && m_wr != 0 && m_wsel != 2'd1);
    chk({tag, ".fwd_load"}, bus.fwd_is_load, m_valid && m_rf && m_wr != 0 && m_wsel == 2'd1);
    chk({tag, ".fwd_wr"}, bus.fwd_wR, m_wr);
    chk({tag, ".fwd_data"}, bus.fwd_data, efd);
    chk({tag, ".cnt"}, bus.bubble_cnt, ecnt[3:0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, bus.mem_valid, 0);
    chk({tag, ".alu"}, bus.mem_alu_c, 0);
    chk({tag, ".rf_we"}, bus.mem_rf_we, 0);
    chk({tag, ".ram_we"}, bus.mem_ram_we, 0);
    chk({tag, ".fwd_we"}, bus.fwd_we, 0);
    chk({tag, ".fwd_data"}, bus.fwd_data, 0);
    chk({tag, ".cnt"}, bus.bubble_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //       v ram rf st fl  alu         rd2         pc4         imm          wr ws  ev er erf fwe ld fwr fdata        cnt
    vt[0] = '{1, 0, 1, 0, 0, 32'h10,     32'h0,      32'h0,      32'h0,       5, 0, 1, 0, 1, 1, 0, 5, 32'h10,      0};
    vt[1] = '{1, 0, 1, 0, 0, 32'h20,     32'h0,      32'h0,      32'h0,       7, 1, 1, 0, 1, 0, 1, 7, 32'h0,       0};
    vt[2] = '{1, 0, 1, 0, 0, 32'h30,     32'h0,      32'h104,    32'h0,       0, 2, 1, 0, 1, 0, 0, 0, 32'h104,     0};
    vt[3] = '{1, 0, 1, 0, 0, 32'h40,     32'h0,      32'h0,      32'hABCD000, 3, 3, 1, 0, 1, 1, 0, 3, 32'hABCD000, 0};
    vt[4] = '{1, 0, 1, 1, 0, 32'h99,     32'h0,      32'h0,      32'h0,       9, 0, 1, 0, 1, 1, 0, 3, 32'hABCD000, 0};
    vt[5] = '{1, 1, 1, 1, 1, 32'h77,     32'h0,      32'h0,      32'h0,       6, 0, 0, 0, 0, 0, 0, 0, 32'h0,       1};
    vt[6] = '{0, 0, 1, 0, 0, 32'h55,     32'h0,      32'h0,      32'h0,       4, 0, 0, 0, 0, 0, 0, 4, 32'h55,      2};
    vt[7] = '{1, 1, 0, 0, 0, 32'h8,      32'hCAFE,   32'h0,      32'h0,       2, 0, 1, 1, 0, 0, 0, 2, 32'h8,       2};

    // Reset state, then vector table.
    #1;
    check_zero("reset");
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].valid, vt[i].alu, vt[i].rd2, vt[i].pc4, vt[i].imm, vt[i].wr,
            vt[i].ram_we, vt[i].rf_we, vt[i].wsel, vt[i].stall, vt[i].flush);
      @(negedge clk);
      chk($sformatf("vec%0d.valid", i), bus.mem_valid, vt[i].e_valid);
      chk($sformatf("vec%0d.ram_we", i), bus.mem_ram_we, vt[i].e_ram);
      chk($sformatf("vec%0d.rf_we", i), bus.mem_rf_we, vt[i].e_rf);
      chk($sformatf("vec%0d.fwd_we", i), bus.fwd_we, vt[i].e_fwe);
      chk($sformatf("vec%0d.fwd_load", i), bus.fwd_is_load, vt[i].e_load);
      chk($sformatf("vec%0d.fwd_wr", i), bus.fwd_wR, vt[i].e_fwr);
      chk($sformatf("vec%0d.fwd_data", i), bus.fwd_data, vt[i].e_fdata);
      chk($sformatf("vec%0d.cnt", i), bus.bubble_cnt, vt[i].e_cnt);
    end

    // Async reset between edges mid-operation.
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst.alu", bus.mem_alu_c, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Stall hold for three cycles, then release.
    drive(1, 32'h10, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h1234, 0, 0, 0, 9, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.alu", i), bus.mem_alu_c, 32'h10);
      chk($sformatf("stall%0d.fwd_wr", i), bus.fwd_wR, 5);
      chk($sformatf("stall%0d.ram_we", i), bus.mem_ram_we, 0);
      chk($sformatf("stall%0d.cnt", i), bus.bubble_cnt, 0);
    end
    bus.stall = 0;
    @(negedge clk);
    chk("release.alu", bus.mem_alu_c, 32'h1234);
    chk("release.ram_we", bus.mem_ram_we, 1);
    chk("release.fwd_wr", bus.fwd_wR, 9);

    // Counter saturation: 20 bubble cycles.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d.cnt", i), bus.bubble_cnt, (i < 15) ? i + 1 : 15);
    end

    // Randomized run against the model, with occasional resets.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 60) == 0);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      rst = 1'b0;
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
